// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : aes_pkg                                                 |
// | Description : Shared AES datapath definitions: block geometry, the    |
// |               SubBytes engine FSM encoding and a byte-slice helper.   |
// | Ports       : none (package)                                          |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NBYTES  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // Byte 0 is the most significant byte of the block, so byte n occupies
   // the slice [aes_byte_msb(n) -: 8].
   function automatic int aes_byte_msb(input int n);
      return AES_BLOCK_W - 1 - 8 * n;
   endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox_canright_verified.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : aes_sbox_canright_verified                              |
// | Description : Combinational AES S-box, forward and inverse. Computes  |
// |               the multiplicative inverse in GF(2^8) (poly 0x11B)      |
// |               combined with the AES affine map or its inverse.        |
// | Ports       : i_byte    in  8  byte to substitute                     |
// |               i_enc_dec in  1  1 = forward S-box, 0 = inverse S-box   |
// |               o_byte    out 8  substituted byte                       |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module aes_sbox_canright_verified (
   input  logic [7:0] i_byte,
   input  logic       i_enc_dec,
   output logic [7:0] o_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = product of x^(2^i) for i = 1..7; maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] t;
      logic [7:0] r;
      t = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         t = gf_mul(t, t);
         r = gf_mul(r, t);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] s);
      return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
   endfunction

   logic [7:0] w_fwd;
   logic [7:0] w_inv;

   assign w_fwd  = affine_fwd(gf_inv(i_byte));
   assign w_inv  = gf_inv(affine_inv(i_byte));
   assign o_byte = i_enc_dec ? w_fwd : w_inv;

endmodule : aes_sbox_canright_verified
`default_nettype wire

// File: rtl/aes_subbytes_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : aes_subbytes_serial                                     |
// | Description : Multi-cycle SubBytes / InvSubBytes engine. Substitutes  |
// |               SBOX_LANES bytes of the 128-bit state per cycle through |
// |               shared S-box lanes, between two valid/ready handshakes. |
// | Ports       : clk        in  1    clock, rising edge                  |
// |               rst        in  1    synchronous active-high reset       |
// |               in_valid   in  1    input state offered                 |
// |               in_ready   out 1    block can accept a state            |
// |               in_data    in  128  input state, byte 0 = [127:120]     |
// |               in_enc_dec in  1    1 = forward, 0 = inverse S-box      |
// |               out_valid  out 1    substituted state available         |
// |               out_ready  in  1    consumer takes the state            |
// |               out_data   out 128  substituted state                   |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module aes_subbytes_serial
   import aes_pkg::*;
#(
   parameter int SBOX_LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   input  logic                   in_enc_dec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data
);

   localparam int NBEATS = AES_NBYTES / SBOX_LANES;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   generate
      if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
            SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
         $error("aes_subbytes_serial: SBOX_LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   aes_fsm_e               r_state;
   aes_fsm_e               w_state_next;
   logic [AES_BLOCK_W-1:0] r_st;
   logic [AES_BLOCK_W-1:0] w_st_next;
   logic                   r_mode;
   logic [BEAT_W-1:0]      r_beat;
   logic                   w_accept;
   logic [7:0]             w_lane_in  [SBOX_LANES];
   logic [7:0]             w_lane_out [SBOX_LANES];

   // Lane j of beat k handles byte k*SBOX_LANES + j. The modulo keeps the
   // read index in range when the beat counter has run past the last beat
   // (only possible outside BUSY, where the lane result is not used).
   generate
      for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
         assign w_lane_in[j] =
            r_st[aes_byte_msb((int'(r_beat) * SBOX_LANES + j) % AES_NBYTES) -: 8];

         aes_sbox_canright_verified u_sbox (
            .i_byte    (w_lane_in[j]),
            .i_enc_dec (r_mode),
            .o_byte    (w_lane_out[j])
         );
      end
   endgenerate

   // Per-byte write enable: only the bytes belonging to the current beat
   // take their lane result, all others hold.
   always_comb begin
      w_st_next = r_st;
      for (int n = 0; n < AES_NBYTES; n++) begin
         if ((n / SBOX_LANES) == int'(r_beat)) begin
            w_st_next[aes_byte_msb(n) -: 8] = w_lane_out[n % SBOX_LANES];
         end
      end
   end

   // Handshake outputs depend on state only; out_ready reaches in_ready in
   // DONE so a finished block and the next accept share one cycle.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = ST_BUSY;
         end
         ST_BUSY: begin
            if (r_beat == LAST_BEAT) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) w_state_next = in_valid ? ST_BUSY : ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_st    <= '0;
         r_mode  <= 1'b1;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_st   <= in_data;
            r_mode <= in_enc_dec;
            r_beat <= '0;
         end else if (r_state == ST_BUSY) begin
            r_st   <= w_st_next;
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   assign out_data = r_st;

endmodule : aes_subbytes_serial
`default_nettype wire
